// File: rtl/spi_bus_sched.sv
// spi_bus_sched: round-robin arbiter that lets three requesters share one SPI master
// and its five slave selects, with chip-select setup, frame gaps and a transfer watchdog.
module spi_bus_sched #(
    parameter int TO_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [8:0]  req_tgt,
    input  logic [47:0] req_cmd,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        ch1_ss_n,
    output logic        ch2_ss_n,
    output logic        ch3_ss_n,
    output logic        trig_ss_n,
    output logic        EEP_ss_n
);
    localparam int CW = $clog2(TO_CYCLES);

    typedef enum logic [1:0] {IDLE, SEL, XFER, DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_last, r_gnt, w_c0, w_c1, w_gnt;
    logic [2:0]  w_tgt;
    logic [15:0] w_cmd;
    logic        w_valid, w_tmo;
    logic [CW-1:0] r_cnt;
    logic [4:0]  r_ss_n;
    logic [2:0]  r_ack, r_err;
    logic [15:0] r_rsp, r_cmd;
    logic        r_wrt;

    // Search order is last+1, last+2, last (mod 3)
    always_comb begin
        w_c0    = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_c1    = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
        w_gnt   = req[w_c0] ? w_c0 : req[w_c1] ? w_c1 : r_last;
        w_tgt   = (w_gnt == 2'd0) ? req_tgt[2:0] : (w_gnt == 2'd1) ? req_tgt[5:3] : req_tgt[8:6];
        w_cmd   = (w_gnt == 2'd0) ? req_cmd[15:0] : (w_gnt == 2'd1) ? req_cmd[31:16] : req_cmd[47:32];
        w_valid = w_tgt <= 3'd4;
        w_tmo   = r_cnt == CW'(TO_CYCLES - 1);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_next = w_valid ? SEL : DONE;
            SEL:     w_next = XFER;
            XFER:    if (spi_done || w_tmo) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 2'd2;
            r_gnt   <= 2'd0;
            r_cnt   <= '0;
            r_ss_n  <= '1;
            r_ack   <= '0;
            r_err   <= '0;
            r_rsp   <= '0;
            r_cmd   <= '0;
            r_wrt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wrt   <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            case (r_state)
                IDLE: if (|req) begin
                    r_gnt <= w_gnt;
                    r_cmd <= w_cmd;
                    if (w_valid) r_ss_n <= ~(5'b1 << w_tgt);
                    else r_err <= 3'b1 << w_gnt;
                end
                SEL: begin
                    r_wrt <= 1'b1;
                    r_cnt <= '0;
                end
                XFER: begin
                    r_cnt <= r_cnt + 1'b1;
                    // done takes priority over a coincident watchdog expiry
                    if (spi_done) begin
                        r_rsp  <= spi_rd;
                        r_ack  <= 3'b1 << r_gnt;
                        r_ss_n <= '1;
                    end else if (w_tmo) begin
                        r_err  <= 3'b1 << r_gnt;
                        r_ss_n <= '1;
                    end
                end
                default: r_last <= r_gnt;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rsp_data  = r_rsp;
    assign spi_cmd   = r_cmd;
    assign spi_wrt   = r_wrt;
    assign busy      = r_state != IDLE;
    assign ch1_ss_n  = r_ss_n[0];
    assign ch2_ss_n  = r_ss_n[1];
    assign ch3_ss_n  = r_ss_n[2];
    assign trig_ss_n = r_ss_n[3];
    assign EEP_ss_n  = r_ss_n[4];
endmodule

// File: tb/tb_spi_bus_sched.sv
// tb_spi_bus_sched: directed vector table plus hand sequences for timeout, late done and reset abort.
module tb_spi_bus_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [8:0]  req_tgt;
    logic [47:0] req_cmd;
    logic [2:0]  ack, err;
    logic [15:0] rsp_data, spi_cmd, spi_rd;
    logic        busy, spi_wrt, spi_done;
    logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;
    logic [4:0]  ss;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  req;
        logic [8:0]  tgt;
        logic [47:0] cmd;
        int          dly;
        logic [15:0] rd;
        logic        drop;
        logic [2:0]  exp_ack;
        logic [2:0]  exp_err;
        logic [15:0] exp_rsp;
        logic [4:0]  exp_ss;
        logic [15:0] exp_cmd;
        int          exp_k;
    } vec_t;

    vec_t tbl[9];
    vec_t v;

    spi_bus_sched #(.TO_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tgt(req_tgt), .req_cmd(req_cmd),
        .ack(ack), .err(err), .rsp_data(rsp_data), .busy(busy),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd),
        .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
        .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
    );

    assign ss = {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Cycle k counts negedges after the grant edge; master answers dly cycles after spi_wrt
    task automatic run(input vec_t t);
        int wk, nw, bad, kk;
        logic got, valid;
        valid = t.exp_ss != 5'h1F;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ss", ss, 5'h1F);
        req = t.req; req_tgt = t.tgt; req_cmd = t.cmd;
        wk = -1; nw = 0; bad = 0; got = 0; kk = 0;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(negedge clk);
            spi_done = 0;
            kk = k;
            if (k == 1 && t.drop) req = 0;
            if (spi_wrt) begin nw++; wk = k; end
            if (ack != 0 || err != 0) got = 1;
            else begin
                if (ss !== t.exp_ss) bad++;
                if (t.dly >= 0 && wk > 0 && k == wk + t.dly) begin spi_done = 1; spi_rd = t.rd; end
            end
        end
        spi_done = 0;
        chk("complete", got, 1);
        chk("latency", kk, t.exp_k);
        chk("ack", ack, t.exp_ack);
        chk("err", err, t.exp_err);
        chk("rsp_data", rsp_data, t.exp_rsp);
        chk("ss_hold", bad, 0);
        chk("ss_done", ss, 5'h1F);
        chk("wrt_count", nw, valid ? 1 : 0);
        chk("wrt_cycle", wk, valid ? 2 : -1);
        chk("spi_cmd", spi_cmd, t.exp_cmd);
        chk("done_busy", busy, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1; req = 0; req_tgt = 0; req_cmd = 0; spi_done = 0; spi_rd = 0;
        //          req     tgt             cmd                                      dly rd       drop ack     err     rsp       ss        cmd       k
        tbl[0] = '{3'b001, 9'b000_000_100, {16'h0, 16'h0, 16'h2A99},               40, 16'h0099, 0, 3'b001, 3'b000, 16'h0099, 5'b01111, 16'h2A99, 43};
        tbl[1] = '{3'b111, 9'b010_001_000, {16'h3333, 16'h2222, 16'h1111},         3, 16'hBEEF, 0, 3'b010, 3'b000, 16'hBEEF, 5'b11101, 16'h2222, 6};
        tbl[2] = '{3'b111, 9'b010_001_000, {16'h3333, 16'h2222, 16'h1111},         0, 16'h1234, 0, 3'b100, 3'b000, 16'h1234, 5'b11011, 16'h3333, 3};
        tbl[3] = '{3'b111, 9'b010_001_000, {16'h3333, 16'h2222, 16'h1111},         5, 16'h5A5A, 0, 3'b001, 3'b000, 16'h5A5A, 5'b11110, 16'h1111, 8};
        tbl[4] = '{3'b010, 9'b000_110_000, {16'h0, 16'hDEAD, 16'h0},               -1, 16'h0, 0, 3'b000, 3'b010, 16'h5A5A, 5'b11111, 16'hDEAD, 1};
        tbl[5] = '{3'b100, 9'b011_000_000, {16'hC0DE, 16'h0, 16'h0},               10, 16'h0F0F, 1, 3'b100, 3'b000, 16'h0F0F, 5'b10111, 16'hC0DE, 13};
        tbl[6] = '{3'b001, 9'b000_000_011, {16'h0, 16'h0, 16'h6161},               -1, 16'h0, 0, 3'b000, 3'b001, 16'h0F0F, 5'b10111, 16'h6161, 66};
        tbl[7] = '{3'b001, 9'b000_000_011, {16'h0, 16'h0, 16'h7171},               63, 16'hABCD, 0, 3'b001, 3'b000, 16'hABCD, 5'b10111, 16'h7171, 66};
        tbl[8] = '{3'b011, 9'b000_000_100, {16'h0, 16'h7A7A, 16'h1B1B},            1, 16'h7777, 0, 3'b010, 3'b000, 16'h7777, 5'b11110, 16'h7A7A, 4};
        repeat (3) @(negedge clk);
        chk("rst_ss", ss, 5'h1F);
        chk("rst_busy", busy, 0);
        chk("rst_wrt", spi_wrt, 0);
        chk("rst_cmd", spi_cmd, 0);
        chk("rst_ackerr", {ack, err}, 0);
        chk("rst_rsp", rsp_data, 0);
        rst = 0;
        foreach (tbl[i]) run(tbl[i]);

        // timeout then a stray spi_done in IDLE must be ignored
        v = '{3'b001, 9'b000_000_000, {16'h0, 16'h0, 16'h5555}, -1, 16'h0, 0, 3'b001 & 3'b000, 3'b001, 16'h7777, 5'b11110, 16'h5555, 66};
        run(v);
        @(negedge clk);
        req = 0; spi_done = 1; spi_rd = 16'hFFFF;
        @(negedge clk);
        spi_done = 0;
        repeat (3) begin
            chk("late_done_ackerr", {ack, err}, 0);
            chk("late_done_busy", busy, 0);
            @(negedge clk);
        end
        chk("late_done_rsp", rsp_data, 16'h7777);

        // reset in the middle of a ch2 transfer granted to requester 1
        req = 3'b010; req_tgt = 9'b000_001_000; req_cmd = {16'h0, 16'h4444, 16'h0};
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = spi_wrt;
        end
        chk("rst_seq_wrt", seen, 1);
        @(negedge clk);
        chk("rst_seq_ch2_low", ch2_ss_n, 0);
        #2 rst = 1;
        #1;
        chk("rst_async_ch2", ch2_ss_n, 1);
        chk("rst_async_ss", ss, 5'h1F);
        chk("rst_async_busy", busy, 0);
        req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ackerr", {ack, err}, 0);
        end
        rst = 0;
        v = '{3'b011, 9'b000_001_100, {16'h0, 16'h4444, 16'h2A2A}, 2, 16'h3C3C, 0, 3'b001, 3'b000, 16'h3C3C, 5'b01111, 16'h2A2A, 5};
        run(v);
        @(negedge clk);
        req = 0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
